// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: shares one SPI mode-0 link between R requesters, round-robin,
// sequencing complete N-bit frames. All outputs are registered.
module spi_master_arbiter #(
    parameter int N       = 8,
    parameter int R       = 2,
    parameter int CLK_DIV = 2
) (
    input  logic           clk_c,
    input  logic           reset_r,
    input  logic [R-1:0]   req_i,
    input  logic [R*N-1:0] data_i,
    output logic [R-1:0]   grant_o,
    output logic [R-1:0]   done_o,
    output logic [N-1:0]   rx_data_o,
    output logic           busy_o,
    output logic           sclk_o,
    output logic           cs_o,
    output logic           mosi_o,
    input  logic           miso_i
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        LOAD_S  = 2'd1,
        SHIFT_S = 2'd2,
        DONE_S  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, win_s;
    logic [N-1:0]    tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic [R-1:0]    grant_q, grant_d, done_q, done_d;
    logic            busy_q, busy_d, sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;

    // Index `offset` positions after `base`, wrapping modulo R.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= R) ? PW'(sum - R) : PW'(sum);
    endfunction

    // Round-robin winner: first set request scanning from ptr upward.
    always_comb begin
        win_s = ptr_q;
        for (int i = R - 1; i >= 0; i--) begin
            win_s = req_i[rr_index(ptr_q, i)] ? rr_index(ptr_q, i) : win_s;
        end
    end

    // Next-state and next-output logic; outputs are set on entry to the state that owns them.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        bit_d   = bit_q;
        div_d   = div_q;
        grant_d = grant_q;
        done_d  = '0;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = 1'b0;
        case (state_q)
            IDLE_S: begin
                grant_d = '0;
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                if (|req_i) begin
                    state_d = LOAD_S;
                    win_d   = win_s;
                    tx_d    = data_i[int'(win_s)*N +: N];
                    mosi_d  = data_i[int'(win_s)*N + N - 1];
                    grant_d = {{(R-1){1'b0}}, 1'b1} << win_s;
                    cs_d    = 1'b1;
                    bit_d   = '0;
                    div_d   = '0;
                end else begin
                    state_d = IDLE_S;
                end
            end
            LOAD_S: begin
                state_d = SHIFT_S;
            end
            SHIFT_S: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[N-2:0], miso_i};
                    end else if (bit_q == CW'(N - 1)) begin
                        // Last falling edge closes the frame.
                        state_d       = DONE_S;
                        sclk_d        = 1'b0;
                        cs_d          = 1'b0;
                        mosi_d        = 1'b0;
                        rxd_d         = rx_q;
                        done_d[win_q] = 1'b1;
                        ptr_d         = rr_index(win_q, 1);
                    end else begin
                        bit_d  = bit_q + CW'(1);
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[N-2];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE_S: begin
                state_d = IDLE_S;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE_S;
            end
        endcase
        busy_d = (state_d != IDLE_S);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_c) begin
        if (reset_r) begin
            state_q <= IDLE_S;
            ptr_q   <= '0;
            win_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign rx_data_o = rxd_q;
    assign busy_o    = busy_q;
    assign sclk_o    = sclk_q;
    assign cs_o      = cs_q;
    assign mosi_o    = mosi_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: instance A (defaults, loopback) and instance B
// (R=3, CLK_DIV=1, behavioural slave) checked frame by frame against a reference model.
module tb_spi_master_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_a;
    logic [15:0] data_a;
    logic [1:0]  grant_a, done_a;
    logic [7:0]  rx_a;
    logic        busy_a, sclk_a, cs_a, mosi_a, miso_a;
    logic [2:0]  req_b;
    logic [23:0] data_b;
    logic [2:0]  grant_b, done_b;
    logic [7:0]  rx_b;
    logic        busy_b, sclk_b, cs_b, mosi_b, miso_b;

    spi_master_arbiter #(.N(8), .R(2), .CLK_DIV(2)) u_dut_a (
        .clk_c(clk), .reset_r(rst), .req_i(req_a), .data_i(data_a), .grant_o(grant_a),
        .done_o(done_a), .rx_data_o(rx_a), .busy_o(busy_a), .sclk_o(sclk_a), .cs_o(cs_a),
        .mosi_o(mosi_a), .miso_i(miso_a));

    spi_master_arbiter #(.N(8), .R(3), .CLK_DIV(1)) u_dut_b (
        .clk_c(clk), .reset_r(rst), .req_i(req_b), .data_i(data_b), .grant_o(grant_b),
        .done_o(done_b), .rx_data_o(rx_b), .busy_o(busy_b), .sclk_o(sclk_b), .cs_o(cs_b),
        .mosi_o(mosi_b), .miso_i(miso_b));

    // Observation mux: sel=0 watches A, sel=1 watches B.
    logic sel = 1'b0, loopback = 1'b1;
    logic [7:0] slave_word = 8'h00;
    logic [3:0] sidx;
    wire [2:0] grant_m = sel ? grant_b : {1'b0, grant_a};
    wire [2:0] done_m  = sel ? done_b : {1'b0, done_a};
    wire [7:0] rx_m    = sel ? rx_b : rx_a;
    wire busy_m = sel ? busy_b : busy_a;
    wire sclk_m = sel ? sclk_b : sclk_a;
    wire cs_m   = sel ? cs_b : cs_a;
    wire mosi_m = sel ? mosi_b : mosi_a;
    wire slave_bit = slave_word[~sidx[2:0]];

    // Slave shift register: MSB presented at select, next bit after each SCLK fall.
    always @(negedge sclk_m or negedge cs_m) sidx <= cs_m ? sidx + 4'd1 : 4'd0;
    assign miso_a = loopback ? mosi_a : slave_bit;
    assign miso_b = loopback ? mosi_b : slave_bit;

    int checks = 0, errors = 0;
    int ptr_a = 0, ptr_b = 0;
    int o_load, o_done, o_rises, o_cs, o_viol;
    logic [7:0] o_mosi, o_rx, o_rx_after;
    logic [2:0] o_grant, o_done_val, o_grant_after;
    logic o_cs_done, o_busy_after, o_cs_after, o_sclk_after;

    function automatic int pick(input logic [2:0] req, input int ptr, input int r);
        for (int i = 0; i < r; i++) if (req[(ptr + i) % r]) return (ptr + i) % r;
        return -1;
    endfunction

    // Called within cycle 0 (IDLE with a request); samples each cycle at negedge.
    task automatic observe_frame(input int drop_cyc, input int rst_cyc);
        int c;
        logic psclk, pmosi;
        bit fin;
        c = 0; psclk = 1'b0; pmosi = 1'b0; fin = 1'b0;
        o_load = -1; o_done = -1; o_rises = 0; o_cs = 0; o_viol = 0; o_mosi = 8'h00;
        o_grant = 3'b000; o_done_val = 3'b000; o_rx = 8'h00; o_cs_done = 1'b1;
        o_grant_after = 3'b111; o_busy_after = 1'b1; o_cs_after = 1'b1;
        o_sclk_after = 1'b1; o_rx_after = 8'hFF;
        while (!fin && c < 200) begin
            @(posedge clk); #1; c++;
            if (c == drop_cyc) begin req_a = 2'b00; req_b = 3'b000; end
            if (c == rst_cyc) rst = 1'b1;
            else if (c == rst_cyc + 1) rst = 1'b0;
            @(negedge clk);
            if ((rst_cyc > 0 && c == rst_cyc + 1) || o_done >= 0) begin
                o_grant_after = grant_m; o_busy_after = busy_m; o_cs_after = cs_m;
                o_sclk_after = sclk_m; o_rx_after = rx_m; fin = 1'b1;
            end else begin
                if (cs_m) o_cs++;
                if (cs_m && o_load < 0) begin o_load = c; o_grant = grant_m; end
                if (sclk_m && !psclk) begin o_rises++; o_mosi = {o_mosi[6:0], pmosi}; end
                if (o_load >= 0 && c != o_load && mosi_m !== pmosi && !(psclk && !sclk_m)) o_viol++;
                if (|done_m) begin o_done = c; o_done_val = done_m; o_rx = rx_m; o_cs_done = cs_m; end
                psclk = sclk_m; pmosi = mosi_m;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 2'b00; req_b = 3'b000; data_a = 16'h0000; data_b = 24'h000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({grant_a, done_a, rx_a, busy_a, sclk_a, cs_a, mosi_a} !== 16'h0000) begin
            errors++; $display("FAIL reset_a: got %h want 0", {grant_a, done_a, rx_a, busy_a, sclk_a, cs_a, mosi_a}); end
        checks++; if ({grant_b, done_b, rx_b, busy_b, sclk_b, cs_b, mosi_b} !== 18'h00000) begin
            errors++; $display("FAIL reset_b: got %h want 0", {grant_b, done_b, rx_b, busy_b, sclk_b, cs_b, mosi_b}); end
        ptr_a = 0; ptr_b = 0;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_single_frame();
        sel = 1'b0; loopback = 1'b1; data_a = 16'h00A5; req_a = 2'b01;
        observe_frame(-1, -1);
        checks++; if ({8'(o_load), 8'(o_done), 8'(o_rises), 8'(o_cs), 8'(o_viol)} !== {8'd1, 8'd34, 8'd8, 8'd33, 8'd0}) begin
            errors++; $display("FAIL single_timing: got load %0d done %0d rises %0d cs %0d viol %0d want 1 34 8 33 0", o_load, o_done, o_rises, o_cs, o_viol); end
        checks++; if (o_mosi !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h want a5", o_mosi); end
        checks++; if ({o_grant, o_done_val, o_rx} !== {3'b001, 3'b001, 8'hA5}) begin
            errors++; $display("FAIL single_result: got grant %b done %b rx %h want 001 001 a5", o_grant, o_done_val, o_rx); end
        checks++; if ({o_busy_after, o_grant_after, o_cs_after} !== 5'b0) begin
            errors++; $display("FAIL single_idle: got busy %b grant %b cs %b want 0", o_busy_after, o_grant_after, o_cs_after); end
        req_a = 2'b00; ptr_a = 1;
    endtask

    task automatic test_round_robin();
        int w;
        @(posedge clk); #1;
        data_a = 16'h2211; req_a = 2'b11;
        for (int f = 0; f < 4; f++) begin
            w = pick({1'b0, req_a}, ptr_a, 2);
            observe_frame(-1, -1);
            if (f == 3) req_a = 2'b00;
            checks++; if ({o_grant, o_done_val, 8'(o_load), 8'(o_done)} !== {3'(1 << w), 3'(1 << w), 8'd1, 8'd34}) begin
                errors++; $display("FAIL rr_grant%0d: got grant %b done %b at %0d/%0d want winner %0d", f, o_grant, o_done_val, o_load, o_done, w); end
            checks++; if (o_rx !== data_a[w*8 +: 8]) begin
                errors++; $display("FAIL rr_rx%0d: got %h want %h", f, o_rx, data_a[w*8 +: 8]); end
            ptr_a = (w + 1) % 2;
        end
    endtask

    task automatic test_back_to_back();
        logic cs_d1, cs_a1;
        int w;
        @(posedge clk); #1;
        data_a = 16'($urandom()); req_a = 2'b01;
        w = pick({1'b0, req_a}, ptr_a, 2);
        observe_frame(-1, -1);
        cs_d1 = o_cs_done; cs_a1 = o_cs_after; ptr_a = (w + 1) % 2;
        w = pick({1'b0, req_a}, ptr_a, 2);
        observe_frame(-1, -1);
        req_a = 2'b00; ptr_a = (w + 1) % 2;
        checks++; if ({cs_d1, cs_a1, 8'(o_load)} !== {1'b0, 1'b0, 8'd1}) begin
            errors++; $display("FAIL b2b_gap: got cs_done %b cs_idle %b load %0d want 0 0 1", cs_d1, cs_a1, o_load); end
        checks++; if ({o_done_val, o_rx} !== {3'b001, data_a[7:0]}) begin
            errors++; $display("FAIL b2b_second: got done %b rx %h want 001 %h", o_done_val, o_rx, data_a[7:0]); end
    endtask

    task automatic test_req_drop();
        @(posedge clk); #1;
        data_a = 16'($urandom()) | 16'h0001; req_a = 2'b01;
        observe_frame(10, -1);
        checks++; if ({8'(o_done), o_done_val, o_rx, o_busy_after} !== {8'd34, 3'b001, data_a[7:0], 1'b0}) begin
            errors++; $display("FAIL drop: got done %0d/%b rx %h busy %b want 34/001 %h 0", o_done, o_done_val, o_rx, o_busy_after, data_a[7:0]); end
        ptr_a = 1;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        data_a = 16'($urandom()); req_a = 2'b01;
        observe_frame(-1, 15);
        req_a = 2'b00; ptr_a = 0;
        checks++; if ({o_cs_after, o_sclk_after, o_busy_after, o_grant_after, o_rx_after} !== 14'h0) begin
            errors++; $display("FAIL reset_mid: got cs %b sclk %b busy %b grant %b rx %h want 0", o_cs_after, o_sclk_after, o_busy_after, o_grant_after, o_rx_after); end
        checks++; if (o_done !== -1) begin errors++; $display("FAIL reset_mid_done: got %0d want -1", o_done); end
        @(posedge clk); #1; req_a = 2'b11;
        observe_frame(-1, -1);
        req_a = 2'b00;
        checks++; if (o_grant !== 3'b001) begin errors++; $display("FAIL reset_ptr: got %b want 001", o_grant); end
        ptr_a = 1;
        @(posedge clk); #1; req_a = 2'b10;
        observe_frame(-1, -1);
        req_a = 2'b00; ptr_a = 0;
        checks++; if ({o_grant, o_done_val} !== {3'b010, 3'b010}) begin
            errors++; $display("FAIL reset_req1: got grant %b done %b want 010 010", o_grant, o_done_val); end
    endtask

    task automatic test_slave_pattern();
        @(posedge clk); #1;
        sel = 1'b1; loopback = 1'b0; slave_word = 8'h3C; data_b = 24'($urandom()); req_b = 3'b001;
        observe_frame(-1, -1);
        req_b = 3'b000; ptr_b = 1;
        checks++; if ({o_rx, 8'(o_done), o_done_val} !== {8'h3C, 8'd18, 3'b001}) begin
            errors++; $display("FAIL slave_rx: got rx %h done %0d/%b want 3c 18/001", o_rx, o_done, o_done_val); end
        checks++; if ({8'(o_load), 8'(o_rises), 8'(o_cs), 8'(o_viol), o_mosi} !== {8'd1, 8'd8, 8'd17, 8'd0, data_b[7:0]}) begin
            errors++; $display("FAIL slave_wave: got load %0d rises %0d cs %0d viol %0d mosi %h want 1 8 17 0 %h", o_load, o_rises, o_cs, o_viol, o_mosi, data_b[7:0]); end
    endtask

    task automatic test_random();
        int w;
        for (int f = 0; f < 8; f++) begin
            @(posedge clk); #1;
            req_b = 3'($urandom_range(1, 7)); data_b = 24'($urandom()); slave_word = 8'($urandom());
            w = pick(req_b, ptr_b, 3);
            observe_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 17)) : -1, -1);
            req_b = 3'b000;
            checks++; if ({o_grant, o_done_val, 8'(o_done)} !== {3'(1 << w), 3'(1 << w), 8'd18}) begin
                errors++; $display("FAIL rand_grant%0d: got grant %b done %b at %0d want winner %0d at 18", f, o_grant, o_done_val, o_done, w); end
            checks++; if ({o_rx, o_mosi} !== {slave_word, data_b[w*8 +: 8]}) begin
                errors++; $display("FAIL rand_data%0d: got rx %h mosi %h want %h %h", f, o_rx, o_mosi, slave_word, data_b[w*8 +: 8]); end
            ptr_b = (w + 1) % 3;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_back_to_back();
        test_req_drop();
        test_reset_mid();
        test_slave_pattern();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

SPI master controller that shares one SPI link between `R` on-chip requesters and sequences complete `N`-bit frames on it. It selects requesters round-robin, generates `sclk_o`/`cs_o`/`mosi_o` for the SPI slave shift register and bit counter on the far side, and captures `miso_i` into a receive register. It sits between the requester logic and the SPI pins, one instance per SPI bus.

## Interface
- `N`, default 8: frame width in bits; must match the slave's data width.
- `R`, default 2: number of requesters, 2..4.
- `CLK_DIV`, default 2: system clocks per SCLK half-period; minimum 1.

Ports:
- `clk_c` in 1: system clock; the only clock, all logic on its rising edge.
- `reset_r` in 1: synchronous, active-high reset.
- `req_i` in R: level request per requester; held high until the matching `done_o` pulse.
- `data_i` in R*N: transmit word per requester; requester k owns bits `[k*N +: N]`.
- `grant_o` out R: one-hot; high for the owning requester from LOAD through DONE.
- `done_o` out R: one-cycle pulse to the owner in DONE.
- `rx_data_o` out N: last received frame; updated in DONE and held until the next DONE.
- `busy_o` out 1: high in every state except IDLE.
- `sclk_o` out 1: SPI clock in mode 0 (idle low).
- `cs_o` out 1: slave enable, active-high; matches the slave `cs` enable.
- `mosi_o` out 1: serial data to the slave, MSB first.
- `miso_i` in 1: serial data from the slave.

## Operation
- FSM has four states: IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - `cs_o` = 0, `sclk_o` = 0, `mosi_o` = 0.
  - If any `req_i` bit is high, pick the winner round-robin and go to LOAD.
- **Arbitration:**
  - Pointer `ptr` (reset 0) gives the highest-priority index.
  - The winner is the first set `req_i` bit scanning `ptr`, `ptr+1`, … modulo R.
  - After a frame completes, `ptr` = winner+1 mod R.
  - Arbitration happens in IDLE only; `req_i` changes during a frame are ignored.
- **LOAD (1 cycle):**
  - Latch the winner's `data_i` into tx shift register; `grant_o` set.
  - `cs_o` = 1; `mosi_o` = tx[N-1]; bit counter = 0; divider = 0; `sclk_o` = 0.
- **SHIFT:**
  - Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and toggles `sclk_o`.
  - On a rising toggle: rx = {rx[N-2:0], `miso_i`}.
  - On a falling toggle: if bit counter == N-1, go to DONE; otherwise increment the counter, shift tx left and drive the new tx[N-1] on `mosi_o`.
- **DONE (1 cycle):**
  - `cs_o` = 0, `sclk_o` = 0.
  - `rx_data_o` <= rx; `done_o[winner]` = 1; update `ptr`.
  - Next state is IDLE; `grant_o` clears there.
- **Requests:** deasserting `req_i` mid-frame does not abort the frame; the frame completes and `done_o` still pulses. A requester still high after `done_o` competes again in IDLE.
- **Reset:** on any cycle, including mid-frame, the next state is IDLE. All outputs, `ptr`, and the counters and shift registers clear to 0. A partial frame is not completed or reported.

## Timing
- Reset values:
  - `grant_o` = 0, `done_o` = 0, `rx_data_o` = 0, `busy_o` = 0.
  - `sclk_o` = 0, `cs_o` = 0, `mosi_o` = 0.
- Latency, counting IDLE with a request as cycle 0:
  - LOAD is cycle 1.
  - SHIFT spans cycles 2 .. 1+2·N·CLK_DIV.
  - DONE is cycle 2+2·N·CLK_DIV; with the defaults this is cycle 34.
- The earliest next LOAD is 2 cycles after DONE (through IDLE). This gives a minimum `cs_o` low gap of 2 cycles between frames.
- SCLK:
  - Period is 2·CLK_DIV cycles, 50% duty, exactly N rising edges per frame.
  - The first rising edge occurs CLK_DIV cycles after LOAD.
- Data setup and sampling:
  - `mosi_o` is stable for CLK_DIV cycles before each rising edge of `sclk_o`.
  - `miso_i` is sampled on the same clock edge that raises `sclk_o`.
- `done_o` and the new `rx_data_o` become visible in the same cycle.
- Simultaneous requests in IDLE are resolved by `ptr` alone; no priority is tied to index.

## Test plan
- **Single frame:** R=2, CLK_DIV=2, req_i=01, data_i[7:0]=8'hA5, miso_i looped from mosi_o.
  - `mosi_o` serializes 1,0,1,0,0,1,0,1 with 8 SCLK rising edges.
  - `done_o`=01 at cycle 34; `rx_data_o`=8'hA5; `cs_o` high for cycles 1–33.
- **Round-robin:** req_i=11 held, data 8'h11 / 8'h22.
  - Grants alternate 01,10,01,10; `done_o` alternates accordingly.
  - Received words alternate 8'h11, 8'h22.
- **Request drop mid-frame:** req_i=01 deasserted at cycle 10.
  - The frame completes; `done_o`=01 at cycle 34; the next state is IDLE with `busy_o`=0.
- **Reset mid-frame:** assert `reset_r` at cycle 15.
  - Cycle 16: `cs_o`=0, `sclk_o`=0, `busy_o`=0, `grant_o`=0, `rx_data_o`=0.
  - A subsequent req_i=10 is granted to requester 1, since `ptr` is back to 0 and requester 0 is idle.
- **Slave pattern:** miso_i driven 8'h3C MSB-first on `sclk_o` falling edges, CLK_DIV=1.
  - `rx_data_o`=8'h3C; `done_o` at cycle 18.
- **Back-to-back:** req_i=01 held.
  - Second LOAD occurs exactly 2 cycles after the first DONE; `cs_o` is low for exactly those 2 cycles.
